pc_thread_sched: RTL

Fine-grained multithread fetch scheduler that owns the per-thread program counters of the pipeline. Each cycle it picks one runnable thread by rotating priority, issues that thread's PC to instruction fetch and advances it. Thread start, halt and branch redirect arrive from the control/execute stages. The block sits between the control path and the instruction memory address port.

---
 rtl/pc_thread_sched_pkg.sv | 36 +++
 rtl/pc_thread_sched_rr_arbiter.sv | 40 ++++
 rtl/pc_thread_sched.sv | 110 +++++++++++
 3 files changed

// File: rtl/pc_thread_sched_pkg.sv
// Shared sizing constants and the per-thread command resolution for the
// multithread fetch scheduler.
package pc_thread_sched_pkg;

  localparam int ADDR_W      = 64;
  localparam int NUM_THREADS = 4;
  localparam int TID_W       = 2;

  localparam logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_0000_0000;
  localparam logic [ADDR_W-1:0] PC_INC   = 64'h0000_0000_0000_0001;

  // Encoding order mirrors command priority: start > halt > redirect.
  typedef enum logic [1:0] {
    CMD_NONE     = 2'd0,
    CMD_REDIRECT = 2'd1,
    CMD_HALT     = 2'd2,
    CMD_START    = 2'd3
  } cmd_e;

  function automatic cmd_e resolve_cmd(input logic start_hit,
                                       input logic halt_hit,
                                       input logic redir_hit);
    cmd_e cmd;
    if (start_hit) begin
      cmd = CMD_START;
    end else if (halt_hit) begin
      cmd = CMD_HALT;
    end else if (redir_hit) begin
      cmd = CMD_REDIRECT;
    end else begin
      cmd = CMD_NONE;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/pc_thread_sched_rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester strictly after the
// pointer, wrapping around. Purely combinational.
module rr_arbiter
  import pc_thread_sched_pkg::*;
(
  input  logic [NUM_THREADS-1:0] i_req,
  input  logic [TID_W-1:0]       i_ptr,
  output logic [NUM_THREADS-1:0] o_grant,
  output logic [TID_W-1:0]       o_grant_tid,
  output logic                   o_any_grant
);

  logic [NUM_THREADS-1:0] w_grant;
  logic [TID_W-1:0]       w_tid;
  logic [TID_W-1:0]       w_idx;
  logic                   w_found;

  // Scan from ptr+1 around to ptr itself; the first hit wins.
  always_comb begin
    w_grant = {NUM_THREADS{1'b0}};
    w_tid   = {TID_W{1'b0}};
    w_idx   = {TID_W{1'b0}};
    w_found = 1'b0;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      w_idx = TID_W'((int'(i_ptr) + k) % NUM_THREADS);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_tid          = w_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_tid = w_tid;
  assign o_any_grant = w_found;

endmodule

// File: rtl/pc_thread_sched.sv
// Fine-grained multithread fetch scheduler: owns per-thread PCs and run state,
// issues one runnable thread's PC per cycle in rotating order.
module pc_thread_sched
  import pc_thread_sched_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_stall,
  input  logic                   i_start_valid,
  input  logic [TID_W-1:0]       i_start_tid,
  input  logic [ADDR_W-1:0]      i_start_pc,
  input  logic                   i_halt_valid,
  input  logic [TID_W-1:0]       i_halt_tid,
  input  logic                   i_redirect_valid,
  input  logic [TID_W-1:0]       i_redirect_tid,
  input  logic [ADDR_W-1:0]      i_redirect_pc,
  output logic                   o_fetch_valid,
  output logic [TID_W-1:0]       o_fetch_tid,
  output logic [ADDR_W-1:0]      o_fetch_pc,
  output logic [NUM_THREADS-1:0] o_active
);

  logic [ADDR_W-1:0]      r_pc [NUM_THREADS];
  logic [NUM_THREADS-1:0] r_active;
  logic [TID_W-1:0]       r_ptr;
  logic                   r_fetch_valid;
  logic [TID_W-1:0]       r_fetch_tid;
  logic [ADDR_W-1:0]      r_fetch_pc;

  cmd_e                   w_cmd [NUM_THREADS];
  logic [NUM_THREADS-1:0] w_mask;
  logic [NUM_THREADS-1:0] w_req;
  logic [NUM_THREADS-1:0] w_grant;
  logic [TID_W-1:0]       w_grant_tid;
  logic                   w_any_grant;
  logic                   w_issue;

  // Any thread addressed by a command this cycle sits out arbitration.
  always_comb begin
    w_mask = {NUM_THREADS{1'b0}};
    for (int i = 0; i < NUM_THREADS; i++) begin
      w_cmd[i] = resolve_cmd(i_start_valid    && (i_start_tid    == TID_W'(i)),
                             i_halt_valid     && (i_halt_tid     == TID_W'(i)),
                             i_redirect_valid && (i_redirect_tid == TID_W'(i)));
      w_mask[i] = (w_cmd[i] != CMD_NONE);
    end
  end

  assign w_req   = r_active & ~w_mask;
  assign w_issue = w_any_grant & ~i_stall;

  rr_arbiter u_arb (
    .i_req       (w_req),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_tid (w_grant_tid),
    .o_any_grant (w_any_grant)
  );

  // Thread state, PCs, pointer and the registered fetch port.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        r_pc[i] <= RESET_PC;
      end
      r_active      <= {NUM_THREADS{1'b0}};
      r_ptr         <= TID_W'(NUM_THREADS - 1);
      r_fetch_valid <= 1'b0;
      r_fetch_tid   <= {TID_W{1'b0}};
      r_fetch_pc    <= {ADDR_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        case (w_cmd[i])
          CMD_START: begin
            r_pc[i]     <= i_start_pc;
            r_active[i] <= 1'b1;
          end
          CMD_HALT: begin
            r_active[i] <= 1'b0;
          end
          CMD_REDIRECT: begin
            r_pc[i] <= i_redirect_pc;
          end
          CMD_NONE: begin
            if (w_issue && w_grant[i]) begin
              r_pc[i] <= r_pc[i] + PC_INC;
            end
          end
          default: begin
            r_pc[i] <= r_pc[i];
          end
        endcase
      end
      if (w_issue) begin
        r_fetch_valid <= 1'b1;
        r_fetch_tid   <= w_grant_tid;
        r_fetch_pc    <= r_pc[w_grant_tid];
        r_ptr         <= w_grant_tid;
      end else begin
        r_fetch_valid <= 1'b0;
      end
    end
  end

  assign o_fetch_valid = r_fetch_valid;
  assign o_fetch_tid   = r_fetch_tid;
  assign o_fetch_pc    = r_fetch_pc;
  assign o_active      = r_active;

endmodule
